// File: rtl/md_unit_pkg.sv
// md_unit_pkg: HI/LO op encodings and default multiply/divide latencies.
package md_unit_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd7
  } md_op_e;
  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/multu/div/divu result and zero-divisor flag.
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        dz
);
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  // one unsigned divider serves both div and divu via sign-magnitude operands
  always_comb begin
    sgn    = !md_op[0];
    dz     = (md_op == MD_DIV || md_op == MD_DIVU) && rt_data == '0;
    prod   = sgn ? 64'($signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data}))
                 : {32'b0, rs_data} * {32'b0, rt_data};
    a_mag  = (sgn && rs_data[31]) ? -rs_data : rs_data;
    b_mag  = (sgn && rt_data[31]) ? -rt_data : rt_data;
    q_mag  = a_mag / (b_mag == '0 ? 32'd1 : b_mag);
    r_mag  = a_mag % (b_mag == '0 ? 32'd1 : b_mag);
    quo    = (sgn && (rs_data[31] ^ rt_data[31])) ? -q_mag : q_mag;
    rem    = (sgn && rs_data[31]) ? -r_mag : r_mag;
    res_hi = md_op[1] ? rem : prod[63:32];
    res_lo = md_op[1] ? quo : prod[31:0];
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle HI/LO multiply/divide unit owning the architectural HI and LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_LAT,
  parameter int DIV_CYCLES  = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [CW-1:0] count;
  logic [31:0]   pend_hi, pend_lo, res_hi, res_lo;
  logic          dz, dz_q, idle;
  md_arith u_arith (
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .dz      (dz)
  );
  assign idle = count == '0;
  assign busy = !idle;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      dz_q    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (idle) begin
      if (start && md_op <= MD_DIVU) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        dz_q    <= dz;
        count   <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (start && md_op == MD_MTHI) hi <= rs_data;
      else if (start && md_op == MD_MTLO) lo <= rs_data;
    end else begin
      count <= count - 1'b1;
      if (count == CW'(1) && !dz_q) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed stimulus, a cycle-stamped reference model compared every cycle, plus literal checks.
module tb_md_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  md_op = 3'd7;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // {dz, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p, q, r;
    if (op < 3'd2) begin
      p = op[0] ? ua * ub : sa * sb;
      return {1'b0, p[63:0]};
    end
    if (b == 32'd0) return {1'b1, 64'd0};
    q = op[0] ? ua / ub : sa / sb;
    r = op[0] ? ua % ub : sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  int          cyc = 0, m_due;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_pend;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_due  <= -1;
      m_pend <= '0;
    end else if (cyc == m_due) begin
      if (!m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (cyc > m_due && start) begin
      if (md_op < 3'd4) begin
        m_pend <= ref_op(md_op, rs_data, rt_data);
        m_due  <= cyc + (md_op[1] ? 10 : 5);
      end else if (md_op == 3'd4) m_hi <= rs_data;
      else if (md_op == 3'd5) m_lo <= rs_data;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (busy !== (cyc <= m_due) || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL model cyc=%0d got busy=%b hi=%h lo=%h want busy=%b hi=%h lo=%h",
                 cyc, busy, hi, lo, cyc <= m_due, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // one-cycle start pulse; returns at the negedge of cycle T+1 with operands scrambled
  task automatic op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'd7; rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (exp_cycles >= 0) chk(name, 32'(n), 32'(exp_cycles));
    else if (n >= 50) chk(name, 32'(n), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op(3'd0, 32'hFFFFFFFF, 32'h2);
    wait_idle("mult_busy", 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    op(3'd1, 32'hFFFFFFFF, 32'h2);
    chk("multu_hold_hi", hi, 32'hFFFFFFFF);
    chk("multu_hold_lo", lo, 32'hFFFFFFFE);
    wait_idle("multu_busy", 5);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    op(3'd2, 32'hFFFFFFF9, 32'h2);
    wait_idle("div_busy", 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    op(3'd2, 32'h7, 32'hFFFFFFFE);
    wait_idle("div_neg_busy", 10);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'h1);
    op(3'd3, 32'h7, 32'h2);
    wait_idle("divu_busy", 10);
    chk("divu_lo", lo, 32'h3);
    chk("divu_hi", hi, 32'h1);
    op(3'd0, 32'h3, 32'h4);
    @(negedge clk);
    op(3'd4, 32'hDEADBEEF, 32'h0);
    wait_idle("mult_mthi_idle", -1);
    chk("busy_ignore_hi", hi, 32'h0);
    chk("busy_ignore_lo", lo, 32'd12);
    op(3'd2, 32'h5, 32'h0);
    wait_idle("dz_busy", 10);
    chk("dz_hi", hi, 32'h0);
    chk("dz_lo", lo, 32'd12);
    op(3'd4, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    op(3'd5, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    op(3'd0, 32'd6, 32'd7);
    wait_idle("b2b_first", 5);
    op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("b2b_first_lo", lo, 32'd42);
    wait_idle("b2b_second", 5);
    chk("b2b_hi", hi, 32'hFFFFFFFE);
    chk("b2b_lo", lo, 32'h1);
    op(3'd6, 32'h11111111, 32'h1);
    chk("noop_busy", {31'b0, busy}, 32'd0);
    chk("noop_hi", hi, 32'hFFFFFFFE);
    op(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_nocommit_hi", hi, 32'h0);
    chk("rst_nocommit_lo", lo, 32'h0);
    chk("rst_nocommit_busy", {31'b0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
